// File: rtl/fsmc_pkg.sv
// Shared constants for the FSMC buffer arbiter: default widths, read-return tags, stats FSM states.
package fsmc_pkg;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 16;
  localparam int unsigned TAG_W = 2;

  // Owner of a read travelling down the RAM return pipeline
  localparam logic [TAG_W-1:0] TAG_NONE = 2'd0;
  localparam logic [TAG_W-1:0] TAG_HOST = 2'd1;
  localparam logic [TAG_W-1:0] TAG_INT  = 2'd2;

  // Statistics path: internal request idle/granted vs. pending and denied
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAITING = 1'b1
  } stat_state_t;

endpackage

// File: rtl/fsmc_rd_tagpipe.sv
// Two-stage read tag pipeline that steers RAM read data back to the host or internal requester.
module fsmc_rd_tagpipe #(
  parameter int unsigned DW = fsmc_pkg::DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [fsmc_pkg::TAG_W-1:0] issue_tag,
  input  logic [DW-1:0]              ram_rdata,
  output logic [DW-1:0]              host_rdata,
  output logic                       host_rvalid,
  output logic [DW-1:0]              int_rdata,
  output logic                       int_rvalid
);
  import fsmc_pkg::*;

  logic [TAG_W-1:0] tag_s1;
  logic [TAG_W-1:0] tag_s2;

  // Stage 1 aligns with the RAM command, stage 2 with ram_rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1 <= TAG_NONE;
      tag_s2 <= TAG_NONE;
    end else begin
      tag_s1 <= issue_tag;
      tag_s2 <= tag_s1;
    end
  end

  // Capture returning data into the owner's result register and pulse its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      int_rdata   <= '0;
      int_rvalid  <= 1'b0;
    end else begin
      host_rvalid <= (tag_s2 == TAG_HOST);
      int_rvalid  <= (tag_s2 == TAG_INT);
      if (tag_s2 == TAG_HOST) begin
        host_rdata <= ram_rdata;
      end
      if (tag_s2 == TAG_INT) begin
        int_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/fsmc_buf_arbiter.sv
// Arbitrates one single-port block RAM between FSMC host strobes (strict priority) and an internal req/gnt port.
module fsmc_buf_arbiter #(
  parameter int unsigned AW         = fsmc_pkg::AW,
  parameter int unsigned DW         = fsmc_pkg::DW,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_idx_wr,
  input  logic          host_data_wr,
  input  logic          host_rd,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] host_index,
  input  logic          int_req,
  input  logic          int_we,
  input  logic [AW-1:0] int_addr,
  input  logic [DW-1:0] int_wdata,
  output logic          int_gnt,
  output logic [DW-1:0] int_rdata,
  output logic          int_rvalid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          int_starved,
  output logic [15:0]   conflict_cnt,
  input  logic          clr_stats
);
  import fsmc_pkg::*;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;

  logic             host_wr_c;
  logic             host_rd_c;
  logic             host_ram_c;
  logic             deny_c;
  logic [TAG_W-1:0] issue_tag_c;

  // Host strobe priority: index load masks data write, data write masks read
  assign host_wr_c  = !host_idx_wr && host_data_wr;
  assign host_rd_c  = !host_idx_wr && !host_data_wr && host_rd;
  assign host_ram_c = host_wr_c || host_rd_c;

  // Internal side wins only when the host is not touching the RAM this cycle
  assign int_gnt = int_req && !host_ram_c;
  assign deny_c  = int_req && !int_gnt;

  // Tag for a read issued this cycle
  always_comb begin
    issue_tag_c = TAG_NONE;
    if (host_rd_c) begin
      issue_tag_c = TAG_HOST;
    end else if (int_gnt && !int_we) begin
      issue_tag_c = TAG_INT;
    end
  end

  // Auto-incrementing host index pointer, wraps at 2^AW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_index <= '0;
    end else if (host_idx_wr) begin
      host_index <= host_wdata[AW-1:0];
    end else if (host_ram_c) begin
      host_index <= host_index + AW'(1);
    end
  end

  // Registered RAM command mux; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= host_ram_c || int_gnt;
      ram_we <= 1'b0;
      if (host_ram_c) begin
        ram_we    <= host_wr_c;
        ram_addr  <= host_index;
        ram_wdata <= host_wdata;
      end else if (int_gnt) begin
        ram_we    <= int_we;
        ram_addr  <= int_addr;
        ram_wdata <= int_wdata;
      end
    end
  end

  fsmc_rd_tagpipe #(
    .DW (DW)
  ) u_tagpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_tag   (issue_tag_c),
    .ram_rdata   (ram_rdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .int_rdata   (int_rdata),
    .int_rvalid  (int_rvalid)
  );

  stat_state_t       state_q;
  stat_state_t       state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              starved_d;
  logic [CNT_W-1:0]  conflict_d;

  // Statistics state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      int_starved  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      int_starved  <= starved_d;
      conflict_cnt <= conflict_d;
    end
  end

  // Statistics next state: consecutive-denial counter, sticky starvation, saturating conflicts
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    starved_d  = int_starved;
    conflict_d = conflict_cnt;

    case (state_q)
      ST_IDLE:    if (deny_c)  state_d = ST_WAITING;
      ST_WAITING: if (!deny_c) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (deny_c) begin
      if (state_q == ST_IDLE) begin
        wait_d = WAIT_W'(1);
      end else if (wait_q != {WAIT_W{1'b1}}) begin
        wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d = wait_q;
      end
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_d = conflict_cnt + CNT_W'(1);
      end
    end

    if (wait_d >= WAIT_W'(STARVE_MAX)) begin
      starved_d = 1'b1;
    end

    if (clr_stats) begin
      starved_d  = 1'b0;
      conflict_d = '0;
    end
  end

endmodule

// File: tb/tb_fsmc_buf_arbiter.sv
// Self-checking bench for fsmc_buf_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fsmc_buf_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_idx_wr, host_data_wr, host_rd;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [8:0]  host_index;
  logic        int_req, int_we;
  logic [8:0]  int_addr;
  logic [15:0] int_wdata;
  logic        int_gnt;
  logic [15:0] int_rdata;
  logic        int_rvalid;
  logic        ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        int_starved;
  logic [15:0] conflict_cnt;
  logic        clr_stats;

  always #5 clk = ~clk;

  fsmc_buf_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_idx_wr  (host_idx_wr),
    .host_data_wr (host_data_wr),
    .host_rd      (host_rd),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .host_index   (host_index),
    .int_req      (int_req),
    .int_we       (int_we),
    .int_addr     (int_addr),
    .int_wdata    (int_wdata),
    .int_gnt      (int_gnt),
    .int_rdata    (int_rdata),
    .int_rvalid   (int_rvalid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .int_starved  (int_starved),
    .conflict_cnt (conflict_cnt),
    .clr_stats    (clr_stats)
  );

  // Synchronous 512x16 block RAM, read data one cycle after the command
  logic [15:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model state
  typedef struct {
    int          due;
    logic [15:0] data;
  } ev_t;

  logic [15:0] ref_mem [512];
  ev_t         hq[$];
  ev_t         iq[$];
  int          m_index;
  int          m_wait;
  bit          m_starved;
  int          m_conflict;
  bit          last_gnt;
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input bit idx, input bit dw, input bit rd, input logic [15:0] wd);
    host_idx_wr  = idx;
    host_data_wr = dw;
    host_rd      = rd;
    host_wdata   = wd;
  endtask

  task automatic set_int(input bit req, input bit we, input logic [8:0] addr, input logic [15:0] wd);
    int_req   = req;
    int_we    = we;
    int_addr  = addr;
    int_wdata = wd;
  endtask

  task automatic model_reset();
    m_index    = 0;
    m_wait     = 0;
    m_starved  = 0;
    m_conflict = 0;
    last_gnt   = 0;
    hq.delete();
    iq.delete();
  endtask

  // One clock cycle: predict from the current inputs, check grant, then check registered results
  task automatic step();
    bit wr, rd, g, denied, exp_en;
    @(negedge clk);
    wr = !host_idx_wr && host_data_wr;
    rd = !host_idx_wr && !host_data_wr && host_rd;
    g  = int_req && !(wr || rd);
    chk("int_gnt", 32'(int_gnt), 32'(g));

    if (host_idx_wr) begin
      m_index = int'(host_wdata) % 512;
    end else if (wr) begin
      ref_mem[m_index] = host_wdata;
      m_index = (m_index + 1) % 512;
    end else if (rd) begin
      hq.push_back('{due: cyc + 3, data: ref_mem[m_index]});
      m_index = (m_index + 1) % 512;
    end
    if (g) begin
      if (int_we) ref_mem[int_addr] = int_wdata;
      else        iq.push_back('{due: cyc + 3, data: ref_mem[int_addr]});
    end
    exp_en = wr || rd || g;

    denied = int_req && !g;
    m_wait = denied ? m_wait + 1 : 0;
    if (clr_stats) begin
      m_starved  = 0;
      m_conflict = 0;
    end else begin
      if (denied && m_conflict < 65535) m_conflict++;
      if (m_wait >= 8) m_starved = 1;
    end
    last_gnt = g;

    @(posedge clk);
    #1;
    cyc++;
    chk("host_index", 32'(host_index), 32'(m_index));
    chk("int_starved", 32'(int_starved), 32'(m_starved));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conflict));
    chk("ram_en", 32'(ram_en), 32'(exp_en));

    while (hq.size() > 0 && hq[0].due < cyc) void'(hq.pop_front());
    while (iq.size() > 0 && iq[0].due < cyc) void'(iq.pop_front());
    if (hq.size() > 0 && hq[0].due == cyc) begin
      chk("host_rvalid", 32'(host_rvalid), 32'd1);
      chk("host_rdata", 32'(host_rdata), 32'(hq[0].data));
      void'(hq.pop_front());
    end else begin
      chk("host_rvalid_idle", 32'(host_rvalid), 32'd0);
    end
    if (iq.size() > 0 && iq[0].due == cyc) begin
      chk("int_rvalid", 32'(int_rvalid), 32'd1);
      chk("int_rdata", 32'(int_rdata), 32'(iq[0].data));
      void'(iq.pop_front());
    end else begin
      chk("int_rvalid_idle", 32'(int_rvalid), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_host_rdata"}, 32'(host_rdata), 32'd0);
    chk({pfx, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({pfx, "_host_index"}, 32'(host_index), 32'd0);
    chk({pfx, "_int_rdata"}, 32'(int_rdata), 32'd0);
    chk({pfx, "_int_rvalid"}, 32'(int_rvalid), 32'd0);
    chk({pfx, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({pfx, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({pfx, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({pfx, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({pfx, "_int_starved"}, 32'(int_starved), 32'd0);
    chk({pfx, "_conflict_cnt"}, 32'(conflict_cnt), 32'd0);
  endtask

  task automatic idle(input int n);
    set_host(0, 0, 0, 16'h0);
    set_int(0, 0, 9'h0, 16'h0);
    clr_stats = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 0;
    set_host(0, 0, 0, 16'h0);
    set_int(0, 0, 9'h0, 16'h0);
    clr_stats = 0;
    model_reset();
    for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0;

    // Reset state
    #12;
    chk_all_zero("reset");
    chk("reset_int_gnt", 32'(int_gnt), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Fill the whole RAM through the host port so every location is known
    set_host(1, 0, 0, 16'h0);
    step();
    for (int i = 0; i < 512; i++) begin
      set_host(0, 1, 0, 16'($urandom));
      step();
    end

    // Index wrap with writes then reads
    set_host(1, 0, 0, 16'h01FE); step();
    set_host(0, 1, 0, 16'hAAAA); step();
    set_host(0, 1, 0, 16'hBBBB); step();
    set_host(1, 0, 0, 16'h01FE); step();
    set_host(0, 0, 1, 16'h0);    step();
    set_host(0, 0, 1, 16'h0);    step();
    idle(1);
    chk("t1_first_rdata", 32'(host_rdata), 32'hAAAA);
    idle(1);
    chk("t1_second_rdata", 32'(host_rdata), 32'hBBBB);
    chk("t1_index_wrap", 32'(host_index), 32'h000);

    // Internal write then read back
    set_int(1, 1, 9'h010, 16'h1234); step();
    set_int(1, 0, 9'h010, 16'h0);    step();
    idle(3);
    chk("t2_int_rdata", 32'(int_rdata), 32'h1234);

    // Host read collides with a pending internal read
    clr_stats = 1; step();
    clr_stats = 0;
    set_int(1, 0, 9'h010, 16'h0);
    set_host(0, 0, 1, 16'h0); step();
    set_host(0, 0, 0, 16'h0); step();
    idle(4);
    chk("t3_conflict", 32'(conflict_cnt), 32'd1);
    chk("t3_int_rdata", 32'(int_rdata), 32'h1234);

    // Continuous host writes starve the internal side
    clr_stats = 1; step();
    clr_stats = 0;
    set_int(1, 1, 9'h020, 16'h5555);
    for (int i = 0; i < 10; i++) begin
      set_host(0, 1, 0, 16'($urandom));
      step();
      if (i == 6) chk("t4_not_starved_7", 32'(int_starved), 32'd0);
      if (i == 7) chk("t4_starved_8", 32'(int_starved), 32'd1);
    end
    set_host(0, 0, 0, 16'h0); step();
    chk("t4_conflict_10", 32'(conflict_cnt), 32'd10);
    set_int(0, 0, 9'h0, 16'h0);
    clr_stats = 1; step();
    clr_stats = 0;
    chk("t4_clr_starved", 32'(int_starved), 32'd0);
    chk("t4_clr_conflict", 32'(conflict_cnt), 32'd0);

    // Index load does not block an internal grant
    set_host(1, 0, 0, 16'hFE55);
    set_int(1, 0, 9'h020, 16'h0);
    step();
    chk("t6_index_load", 32'(host_index), 32'h055);
    idle(3);
    chk("t6_int_rdata", 32'(int_rdata), 32'h5555);

    // Reset in the middle of a host read
    set_host(0, 0, 1, 16'h0);
    step();
    set_host(0, 0, 0, 16'h0);
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("midrd");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(5);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      set_host(0, 0, 0, 16'($urandom));
      if (r < 12)      host_idx_wr = 1;
      else if (r < 35) host_data_wr = 1;
      else if (r < 55) host_rd = 1;
      else if (r < 58) begin host_data_wr = 1; host_rd = 1; end
      else if (r < 60) begin host_idx_wr = 1; host_rd = 1; end
      clr_stats = ($urandom_range(0, 24) == 0);
      if (int_req && !last_gnt) begin
        if ($urandom_range(0, 19) == 0) int_req = 0;
      end else begin
        set_int($urandom_range(0, 9) < 6, 1'($urandom), 9'($urandom), 16'($urandom));
      end
      step();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
